traffic_long_timer: RTL and testbench

// - Long-interval timer for the traffic light controller (TLC). The TLC FSM

---
 rtl/traffic_long_timer.sv | 80 ++++++++
 tb/tb_traffic_long_timer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_long_timer.sv
// Long-interval timer for the traffic light controller: a rising edge on TL_start
// launches a LONG_CYCLES count that ends in a single-cycle registered TL_out pulse.
`timescale 1ns/1ps

module traffic_long_timer #(
  parameter int unsigned LONG_CYCLES = 20,
  parameter int unsigned CNT_W       = 8
) (
  input  logic clk,
  input  logic arst,
  input  logic TL_start,
  output logic TL_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(LONG_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             start_q;
  logic             start_edge;

  // Only the 0->1 transition of TL_start launches a count; a held level does not.
  assign start_edge = TL_start & ~start_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state   <= IDLE;
      count   <= '0;
      start_q <= 1'b0;
      TL_out  <= 1'b0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      start_q <= TL_start;
      // DONE is entered one edge before the pulse is due, so the registered
      // decode lands TL_out exactly LONG_CYCLES edges after the start edge.
      TL_out  <= (state == DONE);
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    count_nxt = '0;
    unique case (state)
      IDLE: begin
        if (start_edge) begin
          state_nxt = RUN;
          count_nxt = CNT_W'(1);
        end
      end
      RUN: begin
        // Further start edges are ignored here: no restart, no extension.
        if (count == LAST_COUNT) begin
          state_nxt = DONE;
        end else begin
          count_nxt = count + CNT_W'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_traffic_long_timer.sv
// Bench for traffic_long_timer: three instances (20, 2 and 255 cycles) driven by
// directed scenarios and a randomized run checked against an arithmetic pulse model.
`timescale 1ns/1ps

module tb_traffic_long_timer;

  localparam int L_A   = 20;
  localparam int L_B   = 2;
  localparam int L_C   = 255;
  localparam int N_RND = 800;
  localparam int N_TOT = N_RND + 300;

  typedef bit stim_t[N_TOT];
  typedef int pulse_q_t[$];

  logic clk     = 1'b0;
  logic arst    = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic start_c = 1'b0;
  logic out_a;
  logic out_b;
  logic out_c;

  int cyc      = 0;
  int pass_cnt = 0;
  int chk_cnt  = 0;
  int q_a[$];
  int q_b[$];
  int q_c[$];

  traffic_long_timer #(.LONG_CYCLES(L_A), .CNT_W(8)) dut_a (
    .clk(clk), .arst(arst), .TL_start(start_a), .TL_out(out_a)
  );
  traffic_long_timer #(.LONG_CYCLES(L_B), .CNT_W(8)) dut_b (
    .clk(clk), .arst(arst), .TL_start(start_b), .TL_out(out_b)
  );
  traffic_long_timer #(.LONG_CYCLES(L_C), .CNT_W(8)) dut_c (
    .clk(clk), .arst(arst), .TL_start(start_c), .TL_out(out_c)
  );

  always #5 clk = ~clk;

  // Number every rising edge and log, per instance, the edges after which TL_out is high.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (out_a === 1'b1) q_a.push_back(cyc);
    if (out_b === 1'b1) q_b.push_back(cyc);
    if (out_c === 1'b1) q_c.push_back(cyc);
  end

  // Return at the falling edge just before rising edge number e.
  task automatic wait_before_edge(input int e);
    while (cyc < e - 1) @(negedge clk);
  endtask

  task automatic clear_logs();
    q_a.delete();
    q_b.delete();
    q_c.delete();
  endtask

  // Expected pulse edges (relative to the first stimulus edge) from the
  // behavioural rules: an accepted edge at n yields a pulse at n+L; edges are
  // accepted only once the previous pulse edge has passed; reset cancels all.
  function automatic pulse_q_t model_pulses(input int len, input stim_t st, input stim_t rs);
    pulse_q_t p;
    int       pend = -1;
    bit       prev = 1'b0;
    for (int n = 0; n < N_TOT; n++) begin
      if (!rs[n]) begin
        pend = -1;
        prev = 1'b0;
      end else begin
        if (n == pend) p.push_back(n);
        if (st[n] && !prev && (pend < 0 || n > pend)) pend = n + len;
        prev = st[n];
      end
    end
    return p;
  endfunction

  task automatic test_reset();
    clear_logs();
    #2;
    chk_cnt++;
    if ({out_a, out_b, out_c} === 3'b000) pass_cnt++;
    else $display("FAIL reset_outputs: got %b, required 000", {out_a, out_b, out_c});
    #1;
    start_a = 1'b1;
    start_b = 1'b1;
    start_c = 1'b1;
    #4;
    chk_cnt++;
    if ({out_a, out_b, out_c} === 3'b000 && q_a.size() + q_b.size() + q_c.size() == 0) pass_cnt++;
    else $display("FAIL reset_hold: outputs %b pulses %0d, required 000 and 0",
                  {out_a, out_b, out_c}, q_a.size() + q_b.size() + q_c.size());
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int k;
    clear_logs();
    k       = cyc + 1;
    arst    = 1'b1;
    start_a = 1'b1;
    wait_before_edge(k + 2);
    start_a = 1'b0;
    wait_before_edge(k + L_A + 6);
    chk_cnt++;
    if (q_a.size() == 1 && q_a[0] == k + L_A) pass_cnt++;
    else $display("FAIL basic_pulse: got %0d pulses first@%0d, required 1 @%0d",
                  q_a.size(), (q_a.size() > 0) ? q_a[0] : -1, k + L_A);
    chk_cnt++;
    if (q_a.size() == 1 && q_a[0] * 10 - 5 == 215) pass_cnt++;
    else $display("FAIL basic_time: rise at %0d ns, required 215 ns",
                  (q_a.size() > 0) ? q_a[0] * 10 - 5 : -1);
  endtask

  task automatic test_level_hold();
    int k;
    clear_logs();
    k       = cyc + 1;
    start_a = 1'b1;
    start_b = 1'b1;
    wait_before_edge(k + 60);
    start_a = 1'b0;
    start_b = 1'b0;
    wait_before_edge(k + 70);
    chk_cnt++;
    if (q_a.size() == 1 && q_a[0] == k + L_A) pass_cnt++;
    else $display("FAIL level_a: got %0d pulses first@%0d, required 1 @%0d",
                  q_a.size(), (q_a.size() > 0) ? q_a[0] : -1, k + L_A);
    chk_cnt++;
    if (q_b.size() == 1 && q_b[0] == k + L_B) pass_cnt++;
    else $display("FAIL level_b: got %0d pulses first@%0d, required 1 @%0d",
                  q_b.size(), (q_b.size() > 0) ? q_b[0] : -1, k + L_B);
  endtask

  task automatic test_retrigger();
    int k;
    clear_logs();
    k       = cyc + 1;
    start_a = 1'b1;
    wait_before_edge(k + 2);
    start_a = 1'b0;
    wait_before_edge(k + 5);
    start_a = 1'b1;
    wait_before_edge(k + 6);
    start_a = 1'b0;
    wait_before_edge(k + L_A + 1);
    start_a = 1'b1;
    wait_before_edge(k + L_A + 2);
    start_a = 1'b0;
    wait_before_edge(k + 2 * L_A + 6);
    chk_cnt++;
    if (q_a.size() == 2 && q_a[0] == k + L_A && q_a[1] == k + 2 * L_A + 1) pass_cnt++;
    else $display("FAIL retrigger: got %0d pulses @%0d,%0d, required 2 @%0d,%0d",
                  q_a.size(), (q_a.size() > 0) ? q_a[0] : -1, (q_a.size() > 1) ? q_a[1] : -1,
                  k + L_A, k + 2 * L_A + 1);
  endtask

  task automatic test_abort();
    int k;
    clear_logs();
    k       = cyc + 1;
    start_a = 1'b1;
    start_c = 1'b1;
    wait_before_edge(k + 2);
    start_a = 1'b0;
    start_c = 1'b0;
    wait_before_edge(k + 10);
    arst = 1'b0;
    wait_before_edge(k + 12);
    arst = 1'b1;
    wait_before_edge(k + L_C + 10);
    chk_cnt++;
    if (q_a.size() == 0) pass_cnt++;
    else $display("FAIL abort_a: got %0d pulses, required 0", q_a.size());
    chk_cnt++;
    if (q_c.size() == 0) pass_cnt++;
    else $display("FAIL abort_c: got %0d pulses, required 0", q_c.size());
  endtask

  task automatic test_reset_toggle();
    clear_logs();
    arst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start_a = 1'($urandom_range(0, 1));
      start_b = 1'($urandom_range(0, 1));
      start_c = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
    arst    = 1'b1;
    wait_before_edge(cyc + 300);
    chk_cnt++;
    if (q_a.size() + q_b.size() + q_c.size() == 0) pass_cnt++;
    else $display("FAIL reset_toggle: got %0d/%0d/%0d pulses, required 0/0/0",
                  q_a.size(), q_b.size(), q_c.size());
  endtask

  task automatic test_sweep();
    int k;
    clear_logs();
    k       = cyc + 1;
    start_a = 1'b1;
    start_b = 1'b1;
    start_c = 1'b1;
    wait_before_edge(k + 1);
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
    wait_before_edge(k + L_C + 5);
    chk_cnt++;
    if (q_b.size() == 1 && q_b[0] == k + L_B) pass_cnt++;
    else $display("FAIL sweep_2: got %0d pulses first@%0d, required 1 @%0d",
                  q_b.size(), (q_b.size() > 0) ? q_b[0] : -1, k + L_B);
    chk_cnt++;
    if (q_a.size() == 1 && q_a[0] == k + L_A) pass_cnt++;
    else $display("FAIL sweep_20: got %0d pulses first@%0d, required 1 @%0d",
                  q_a.size(), (q_a.size() > 0) ? q_a[0] : -1, k + L_A);
    chk_cnt++;
    if (q_c.size() == 1 && q_c[0] == k + L_C) pass_cnt++;
    else $display("FAIL sweep_255: got %0d pulses first@%0d, required 1 @%0d",
                  q_c.size(), (q_c.size() > 0) ? q_c[0] : -1, k + L_C);
  endtask

  task automatic test_random();
    stim_t    st_a;
    stim_t    st_b;
    stim_t    st_c;
    stim_t    rs;
    pulse_q_t exp_a;
    pulse_q_t exp_b;
    pulse_q_t exp_c;
    int       base;
    int       rst_left = 0;
    bit       la = 1'b0;
    bit       lb = 1'b0;
    bit       lc = 1'b0;
    for (int n = 0; n < N_TOT; n++) begin
      if (n < N_RND) begin
        if (rst_left > 0) begin
          rs[n] = 1'b0;
          rst_left--;
        end else if ($urandom_range(0, 199) == 0) begin
          rs[n]    = 1'b0;
          rst_left = 1;
        end else begin
          rs[n] = 1'b1;
        end
        if ($urandom_range(0, 5) == 0)  la = ~la;
        if ($urandom_range(0, 3) == 0)  lb = ~lb;
        if ($urandom_range(0, 39) == 0) lc = ~lc;
      end else begin
        rs[n] = 1'b1;
        la    = 1'b0;
        lb    = 1'b0;
        lc    = 1'b0;
      end
      st_a[n] = la;
      st_b[n] = lb;
      st_c[n] = lc;
    end
    exp_a = model_pulses(L_A, st_a, rs);
    exp_b = model_pulses(L_B, st_b, rs);
    exp_c = model_pulses(L_C, st_c, rs);

    clear_logs();
    base = cyc + 1;
    for (int n = 0; n < N_TOT; n++) begin
      wait_before_edge(base + n);
      arst    = rs[n];
      start_a = st_a[n];
      start_b = st_b[n];
      start_c = st_c[n];
    end
    wait_before_edge(base + N_TOT + 1);

    chk_cnt++;
    if (q_a.size() == exp_a.size()) pass_cnt++;
    else $display("FAIL rnd_count_20: got %0d pulses, required %0d", q_a.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < q_a.size(); i++) begin
      chk_cnt++;
      if (q_a[i] - base == exp_a[i]) pass_cnt++;
      else $display("FAIL rnd_pulse_20[%0d]: got edge %0d, required %0d", i, q_a[i] - base, exp_a[i]);
    end
    chk_cnt++;
    if (q_b.size() == exp_b.size()) pass_cnt++;
    else $display("FAIL rnd_count_2: got %0d pulses, required %0d", q_b.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < q_b.size(); i++) begin
      chk_cnt++;
      if (q_b[i] - base == exp_b[i]) pass_cnt++;
      else $display("FAIL rnd_pulse_2[%0d]: got edge %0d, required %0d", i, q_b[i] - base, exp_b[i]);
    end
    chk_cnt++;
    if (q_c.size() == exp_c.size()) pass_cnt++;
    else $display("FAIL rnd_count_255: got %0d pulses, required %0d", q_c.size(), exp_c.size());
    for (int i = 0; i < exp_c.size() && i < q_c.size(); i++) begin
      chk_cnt++;
      if (q_c[i] - base == exp_c[i]) pass_cnt++;
      else $display("FAIL rnd_pulse_255[%0d]: got edge %0d, required %0d", i, q_c[i] - base, exp_c[i]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_level_hold();
    test_retrigger();
    test_abort();
    test_reset_toggle();
    test_sweep();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
